// File: rtl/flag_run_extract_if.sv
// Segment stream from the run extractor to the blob/feature stage.
// The master drives the segment record and valid; the slave returns ready.
interface flag_run_extract_if #(
  parameter int unsigned X_W = 11,
  parameter int unsigned Y_W = 11
);
  logic           o_seg_vld;
  logic           i_seg_rdy;
  logic [Y_W-1:0] o_seg_y;
  logic [X_W-1:0] o_seg_xs;
  logic [X_W-1:0] o_seg_xe;

  modport master (output o_seg_vld, o_seg_y, o_seg_xs, o_seg_xe, input i_seg_rdy);
  modport slave  (input o_seg_vld, o_seg_y, o_seg_xs, o_seg_xe, output i_seg_rdy);
endinterface

// File: rtl/flag_run_extract.sv
// Collapses horizontal runs of foreground flags into {y, x_start, x_end} segment
// records, queued in a first-word-fall-through FIFO, with per-frame count and overflow.
module flag_run_extract #(
  parameter int unsigned X_W        = 11,
  parameter int unsigned Y_W        = 11,
  parameter int unsigned MIN_LEN    = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_vld,
  input  logic                    i_flag,
  input  logic                    i_sof,
  input  logic                    i_eol,
  flag_run_extract_if.master      seg,
  output logic [15:0]             o_frame_segs,
  output logic                    o_ovf
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = X_W + 1;
  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;

  typedef struct packed {
    logic [Y_W-1:0] row;
    logic [X_W-1:0] xs;
    logic [X_W-1:0] xe;
  } seg_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic [X_W-1:0]  run_xs;
  seg_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     frame_segs;
  logic            ovf;

  logic [X_W-1:0]  cur_x;
  logic [Y_W-1:0]  cur_y;
  state_t          cur_state;
  logic            close;
  logic [X_W-1:0]  close_xs;
  logic [X_W-1:0]  close_xe;
  logic [LW-1:0]   run_len;
  logic            full;
  logic            push;
  logic            pop;
  logic            push_ok;
  logic            drop;

  // Effective beat position/state: a start-of-frame beat restarts at (0,0) from IDLE,
  // which also discards any run left open by the previous frame.
  always_comb begin
    cur_x     = i_sof ? '0 : x;
    cur_y     = i_sof ? '0 : y;
    cur_state = i_sof ? IDLE : state;
    close     = 1'b0;
    close_xs  = run_xs;
    close_xe  = cur_x;
    if (i_vld) begin
      if (cur_state == IDLE) begin
        if (i_flag && i_eol) begin
          close    = 1'b1;
          close_xs = cur_x;
        end
      end else if (!i_flag) begin
        close    = 1'b1;
        close_xe = cur_x - X_W'(1);
      end else if (i_eol) begin
        close = 1'b1;
      end
    end
    run_len = LW'(close_xe) - LW'(close_xs) + LW'(1);
  end

  // Fullness is judged before the pop, so a simultaneous pop frees the slot.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign push    = close && (run_len >= LW'(MIN_LEN));
  assign pop     = (count != '0) && seg.i_seg_rdy;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      run_xs     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_segs <= '0;
      ovf        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (i_vld) begin
        if (i_eol) begin
          x <= '0;
          y <= (cur_y == Y_MAX) ? Y_MAX : cur_y + Y_W'(1);
        end else begin
          x <= (cur_x == X_MAX) ? X_MAX : cur_x + X_W'(1);
          y <= cur_y;
        end
        if (i_flag && !i_eol && cur_state == IDLE) run_xs <= cur_x;
        state <= (i_flag && !i_eol) ? RUN : IDLE;
      end

      if (push_ok) begin
        mem[wr_ptr] <= '{row: cur_y, xs: close_xs, xe: close_xe};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);

      // Start-of-frame clears the stats before this beat's own push/drop lands.
      if (i_vld && i_sof) begin
        frame_segs <= push_ok ? 16'd1 : 16'd0;
        ovf        <= drop;
      end else begin
        if (push_ok && frame_segs != 16'hFFFF) frame_segs <= frame_segs + 16'd1;
        if (drop) ovf <= 1'b1;
      end
    end
  end

  assign seg.o_seg_vld = (count != '0);
  assign seg.o_seg_y   = mem[rd_ptr].row;
  assign seg.o_seg_xs  = mem[rd_ptr].xs;
  assign seg.o_seg_xe  = mem[rd_ptr].xe;
  assign o_frame_segs  = frame_segs;
  assign o_ovf         = ovf;
endmodule

// File: tb/tb_flag_run_extract.sv
// Directed bench for flag_run_extract: lines are scanned for runs up front, a queue
// model of the FIFO is checked every cycle, and literal expectations pin key results.
module tb_flag_run_extract;
  localparam int unsigned X_W        = 11;
  localparam int unsigned Y_W        = 11;
  localparam int unsigned MIN_LEN    = 2;
  localparam int unsigned FIFO_DEPTH = 8;

  typedef struct packed {
    logic [Y_W-1:0] row;
    logic [X_W-1:0] xs;
    logic [X_W-1:0] xe;
  } seg_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_vld, i_flag, i_sof, i_eol;
  logic [15:0] o_frame_segs;
  logic        o_ovf;

  flag_run_extract_if #(.X_W(X_W), .Y_W(Y_W)) sif ();

  flag_run_extract #(
    .X_W(X_W), .Y_W(Y_W), .MIN_LEN(MIN_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_flag(i_flag), .i_sof(i_sof),
    .i_eol(i_eol), .seg(sif), .o_frame_segs(o_frame_segs), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: expected FIFO contents and frame stats
  seg_t        mq[$];
  seg_t        dlog[$];
  logic [15:0] m_fs;
  logic        m_ovf;
  bit          m_push;
  seg_t        m_seg;
  bit          popped, was_full;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input int row, input int xs, input int xe);
    chk({nm, "_present"}, 32'(dlog.size() > idx), 32'd1);
    if (dlog.size() > idx) begin
      chk({nm, "_y"},  32'(dlog[idx].row), 32'(row));
      chk({nm, "_xs"}, 32'(dlog[idx].xs),  32'(xs));
      chk({nm, "_xe"}, 32'(dlog[idx].xe),  32'(xe));
    end
  endtask

  // FIFO model: stats clear on sof, pop before push but fullness seen before pop
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_fs  = 16'd0;
      m_ovf = 1'b0;
    end else begin
      popped   = (mq.size() != 0) && sif.i_seg_rdy;
      was_full = (mq.size() == FIFO_DEPTH);
      if (i_vld && i_sof) begin
        m_fs  = 16'd0;
        m_ovf = 1'b0;
      end
      if (popped) void'(mq.pop_front());
      if (m_push) begin
        if (!was_full || popped) begin
          mq.push_back(m_seg);
          if (m_fs != 16'hFFFF) m_fs = m_fs + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Record every segment the DUT hands over
  always @(posedge clk) begin
    if (rst_n && sif.o_seg_vld && sif.i_seg_rdy)
      dlog.push_back('{row: sif.o_seg_y, xs: sif.o_seg_xs, xe: sif.o_seg_xe});
  end

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("seg_vld", 32'(sif.o_seg_vld), 32'(mq.size() != 0));
    chk("frame_segs", 32'(o_frame_segs), 32'(m_fs));
    chk("ovf", 32'(o_ovf), 32'(m_ovf));
    if (mq.size() != 0) begin
      chk("head_y",  32'(sif.o_seg_y),  32'(mq[0].row));
      chk("head_xs", 32'(sif.o_seg_xs), 32'(mq[0].xs));
      chk("head_xe", 32'(sif.o_seg_xe), 32'(mq[0].xe));
    end
  end

  // Drive one line fragment; runs are found by scanning the flag word beforehand
  task automatic send_line(input logic [15:0] fl, input int len, input int x0, input int row,
                           input bit sof, input bit eol, input bit rdy, input int rdy_pulse);
    bit has[16];
    int sxs[16];
    int sxe[16];
    int k, s, e, c;
    for (int i = 0; i < 16; i++) begin
      has[i] = 1'b0; sxs[i] = 0; sxe[i] = 0;
    end
    k = 0;
    while (k < len) begin
      if (fl[k]) begin
        s = k;
        while (k < len && fl[k]) k++;
        e = k - 1;
        c = (e == len - 1) ? (eol ? e : -1) : e + 1;
        if (c >= 0 && (e - s + 1) >= MIN_LEN) begin
          has[c] = 1'b1; sxs[c] = x0 + s; sxe[c] = x0 + e;
        end
      end else begin
        k++;
      end
    end
    for (int b = 0; b < len; b++) begin
      @(negedge clk);
      i_vld  = 1'b1;
      i_flag = fl[b];
      i_sof  = sof && (b == 0);
      i_eol  = eol && (b == len - 1);
      sif.i_seg_rdy = (b == rdy_pulse) ? 1'b1 : rdy;
      m_push = has[b];
      m_seg  = '{row: Y_W'(row), xs: X_W'(sxs[b]), xe: X_W'(sxe[b])};
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) begin
      @(negedge clk);
      i_vld = 1'b0; i_flag = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
      m_push = 1'b0;
      sif.i_seg_rdy = rdy;
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_vld"}, 32'(sif.o_seg_vld), 32'd0);
    chk({nm, "_y"},   32'(sif.o_seg_y),   32'd0);
    chk({nm, "_xs"},  32'(sif.o_seg_xs),  32'd0);
    chk({nm, "_xe"},  32'(sif.o_seg_xe),  32'd0);
    chk({nm, "_fs"},  32'(o_frame_segs),  32'd0);
    chk({nm, "_ovf"}, 32'(o_ovf),         32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_vld = 1'b0; i_flag = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
    sif.i_seg_rdy = 1'b1;
    m_push = 1'b0;
    m_seg  = '0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Row 0: run x=3..6 closes on the x=7 beat
    send_line(16'h0078, 16, 0, 0, 1'b1, 1'b1, 1'b1, -1);
    idle(3, 1'b1);
    chk_log("t1_seg", 0, 0, 3, 6);
    chk("t1_frame_segs", 32'(o_frame_segs), 32'd1);

    // Row 1 empty; row 2 single pixel at x=5 and run 12..15 ending on eol; row 3 at x=0..1
    send_line(16'h0000, 16, 0, 1, 1'b0, 1'b1, 1'b1, -1);
    send_line(16'hF020, 16, 0, 2, 1'b0, 1'b1, 1'b1, -1);
    idle(3, 1'b1);
    chk("t2_log_size", 32'(dlog.size()), 32'd2);
    chk_log("t2_seg", 1, 2, 12, 15);
    send_line(16'h0003, 16, 0, 3, 1'b0, 1'b1, 1'b1, -1);
    idle(3, 1'b1);
    chk_log("t2_next_row", 2, 3, 0, 1);

    // Ten runs with the consumer stalled: eight queued, two dropped
    for (int r = 0; r < 10; r++)
      send_line(16'h001C, 16, 0, r, r == 0, 1'b1, 1'b0, -1);
    idle(2, 1'b0);
    chk("t3_ovf", 32'(o_ovf), 32'd1);
    chk("t3_frame_segs", 32'(o_frame_segs), 32'd8);
    chk("t3_model_depth", 32'(mq.size()), 32'd8);
    chk("t3_head_y", 32'(sif.o_seg_y), 32'd0);
    idle(12, 1'b1);
    chk("t3_log_size", 32'(dlog.size()), 32'd11);
    for (int i = 0; i < 8; i++) chk_log("t3_drain", 3 + i, i, 2, 4);

    // Full FIFO: push and pop on the same edge
    for (int r = 0; r < 8; r++)
      send_line(16'h001C, 16, 0, r, r == 0, 1'b1, 1'b0, -1);
    send_line(16'hC000, 16, 0, 8, 1'b0, 1'b1, 1'b0, 15);
    idle(2, 1'b0);
    chk("t4_ovf", 32'(o_ovf), 32'd0);
    chk("t4_frame_segs", 32'(o_frame_segs), 32'd9);
    chk("t4_model_depth", 32'(mq.size()), 32'd8);
    idle(12, 1'b1);
    chk("t4_log_size", 32'(dlog.size()), 32'd20);
    chk_log("t4_popped", 11, 0, 2, 4);
    chk_log("t4_last", 19, 8, 14, 15);

    // Open run 9..11 discarded by a new frame; the sof beat itself has no flag
    send_line(16'h0E06, 12, 0, 0, 1'b1, 1'b0, 1'b1, -1);
    send_line(16'h0000, 1, 0, 0, 1'b1, 1'b0, 1'b1, -1);
    idle(2, 1'b1);
    chk("t5_frame_segs", 32'(o_frame_segs), 32'd0);
    chk("t5_ovf", 32'(o_ovf), 32'd0);
    send_line(16'h000C, 15, 1, 0, 1'b0, 1'b1, 1'b1, -1);
    idle(3, 1'b1);
    chk("t5_log_size", 32'(dlog.size()), 32'd22);
    chk_log("t5_before_sof", 20, 0, 1, 2);
    chk_log("t5_after_sof", 21, 0, 3, 4);
    chk("t5_frame_segs_after", 32'(o_frame_segs), 32'd1);

    // Reset with three segments queued and a run open
    send_line(16'h6666, 15, 0, 1, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    i_vld = 1'b0; i_flag = 1'b0; m_push = 1'b0;
    chk("t6_model_depth", 32'(mq.size()), 32'd3);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("t6_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_line(16'h0030, 16, 0, 0, 1'b0, 1'b1, 1'b1, -1);
    idle(3, 1'b1);
    chk("t6_log_size", 32'(dlog.size()), 32'd23);
    chk_log("t6_after_reset", 22, 0, 4, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flag_run_extract.md
Name: flag_run_extract

Overview:
- Downstream of the adaptive threshold stage. Consumes its per-pixel foreground flag stream, framed by start-of-frame and end-of-line markers.
- Collapses each horizontal run of flagged pixels into one segment record {y, x_start, x_end}.
- Buffers segments in a small FIFO and presents them on a valid/ready interface to the blob/feature stage.
- Also reports per-frame segment count and a sticky overflow flag.

Parameters:
X_W, 11, width of the column counter and of x_start/x_end fields
Y_W, 11, width of the row counter and of the y field
MIN_LEN, 2, minimum run length in pixels for a run to emit a segment (1..2^X_W)
FIFO_DEPTH, 8, segment FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_vld  in  1  pixel beat qualifier; i_flag/i_sof/i_eol sampled only when high
i_flag  in  1  foreground flag for current pixel
i_sof  in  1  first pixel of frame (with i_vld)
i_eol  in  1  last pixel of current line (with i_vld)
o_seg_vld  out  1  segment available at FIFO head
i_seg_rdy  in  1  consumer accepts head when o_seg_vld & i_seg_rdy
o_seg_y  out  Y_W  row of head segment
o_seg_xs  out  X_W  first column of run
o_seg_xe  out  X_W  last column of run (inclusive)
o_frame_segs  out  16  segments accepted into FIFO since last i_sof, saturating
o_ovf  out  1  sticky: segment dropped on full FIFO since last i_sof

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0; FIFO empty; x=0, y=0.
  - Run state IDLE; o_seg_vld=0.
- Position tracking, on accepted beats only:
  - Current beat position is (x, y). i_sof forces the beat's position to (0,0).
  - After a beat: if i_eol, then x<=0 and y<=y+1 (saturating at 2^Y_W-1); else x<=x+1 (saturating at 2^X_W-1).
  - i_sof and i_eol on the same beat: the frame is one pixel wide. Position (0,0), then x<=0, y<=1.
- Run FSM, states IDLE and RUN, evaluated per beat with effective position (x, y):
  - IDLE & i_flag: record xs<=x. If i_eol as well, the run is one pixel [x,x]; evaluate emit and stay IDLE. Otherwise go to RUN.
  - RUN & i_flag & !i_eol: stay RUN.
  - RUN & i_flag & i_eol: close the run [xs, x]; evaluate emit; go to IDLE.
  - RUN & !i_flag: close the run [xs, x-1]; evaluate emit; go to IDLE. A new run cannot start on this beat because its flag is 0.
  - i_sof while in RUN: the open run from the previous frame is discarded without emit. The i_sof beat is then processed from IDLE.
  - Runs never continue across i_eol.
- Emit:
  - Length = xe - xs + 1, computed in X_W+1 bits.
  - If length >= MIN_LEN, push {y, xs, xe} using the y of the closing beat.
  - When the run closes on a !i_flag beat, that beat is in the same row as the run (the row changes only after an i_eol beat). Its y is therefore the run's row.
- FIFO:
  - First-word-fall-through. o_seg_vld = !empty; head fields stay stable while o_seg_vld & !i_seg_rdy.
  - A push at edge N is visible on o_seg_vld after edge N, i.e. 1-cycle latency from the closing beat.
  - Full is judged before the pop. A push and a pop at the same edge while full are both accepted; count is unchanged and no overflow.
  - A push while full with no pop is dropped: o_ovf<=1, o_frame_segs not incremented.
  - Empty with push: no pop is possible that cycle.
- Per-frame counters:
  - On an i_sof beat, o_frame_segs and o_ovf clear before that beat's own push/overflow update is applied. A single-pixel run on the sof beat therefore counts for the new frame.
  - o_frame_segs saturates at 16'hFFFF.
  - The FIFO contents are NOT flushed on i_sof; already-queued segments still drain.
- Idle cycles (i_vld=0): no state change except the FIFO pop.
- Reset asserted mid-operation clears everything immediately, including queued segments.

Test Plan:
- MIN_LEN=2, 16-px lines. Row 0 flags at x=3..6, i_seg_rdy=1 -> one segment y=0 xs=3 xe=6, o_seg_vld high the cycle after the x=7 beat; o_frame_segs=1.
- Run x=12..15 ending on i_eol in row 2; isolated flag at x=5 in row 2 -> segment y=2 xs=12 xe=15 only (the single pixel is below MIN_LEN); next row starts y=3, x=0.
- i_seg_rdy=0, 10 qualifying runs with FIFO_DEPTH=8 -> 8 queued; o_ovf=1; o_frame_segs=8. Release rdy -> the first 8 drain in order with stable fields while stalled.
- FIFO full, push and pop on the same edge -> push accepted, o_ovf stays 0, occupancy stays 8.
- Run open at x=9..11 (no i_eol), then i_sof beat with i_flag=0 -> no segment for the open run; o_frame_segs=0, o_ovf=0; next beat has x=1, y=0.
- Assert rst_n=0 with 3 segments queued and in RUN -> o_seg_vld=0, all outputs 0 during reset; after release the first segment reports y=0.
